// File: rtl/addsub_result_stage_if.sv
// Handshake bundle for the add/sub result capture stage.
//   in_*  : producer side (result, operands, mode, carry-out) with valid/ready
//   out_* : consumer side (FIFO head result and flags) with valid/ready
// slave  = the capture stage, master = the producer/consumer environment.
interface addsub_result_stage_if #(
    parameter int unsigned W = 4
);
    localparam int unsigned FLAG_W = 5;

    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_a;
    logic [W-1:0]      in_b;
    logic              in_mode;
    logic [W-1:0]      in_s;
    logic              in_cout;

    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_s;
    logic [FLAG_W-1:0] out_flags;

    modport slave (
        input  in_valid, in_a, in_b, in_mode, in_s, in_cout, out_ready,
        output in_ready, out_valid, out_s, out_flags
    );

    modport master (
        output in_valid, in_a, in_b, in_mode, in_s, in_cout, out_ready,
        input  in_ready, out_valid, out_s, out_flags
    );
endinterface

// File: rtl/addsub_result_stage.sv
// Registered capture stage behind the 4-bit add/subtract datapath.
// Derives {ovf, neg, zero, borrow, carry} at push, buffers results in a
// 2-entry FIFO and keeps saturating counters of popped results/overflows.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   bus (slave)        : in_* valid/ready producer side, out_* valid/ready head
//   clr                : synchronous clear of the statistics counters only
//   res_count          : results popped (saturating)
//   ovf_count          : popped results with ovf=1 (saturating)
module addsub_result_stage #(
    parameter int unsigned W     = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    addsub_result_stage_if.slave bus,
    input  logic                 clr,
    output logic [CNT_W-1:0]     res_count,
    output logic [CNT_W-1:0]     ovf_count
);
    localparam int unsigned FLAG_W = 5;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned OVF_B  = 4;

    logic [W-1:0]      mem_s       [DEPTH];
    logic [FLAG_W-1:0] mem_flags   [DEPTH];
    logic [W-1:0]      mem_s_n     [DEPTH];
    logic [FLAG_W-1:0] mem_flags_n [DEPTH];

    logic              wr_ptr, wr_ptr_n;
    logic              rd_ptr, rd_ptr_n;
    logic [1:0]        count, count_n;
    logic [CNT_W-1:0]  res_count_n, ovf_count_n;

    logic              push_c, pop_c;
    logic [FLAG_W-1:0] in_flags_c;
    logic              ovf_c;

    // Flag derivation from the incoming result.
    always_comb begin
        ovf_c = 1'b0;
        if (bus.in_mode) begin
            ovf_c = (bus.in_a[W-1] != bus.in_b[W-1]) & (bus.in_s[W-1] != bus.in_a[W-1]);
        end else begin
            ovf_c = (bus.in_a[W-1] == bus.in_b[W-1]) & (bus.in_s[W-1] != bus.in_a[W-1]);
        end
        in_flags_c = {ovf_c,
                      bus.in_s[W-1],
                      (bus.in_s == '0),
                      ~bus.in_cout & bus.in_mode,
                      bus.in_cout & ~bus.in_mode};
    end

    // FIFO and counter next-state.
    always_comb begin
        push_c      = bus.in_valid & bus.in_ready;
        pop_c       = bus.out_valid & bus.out_ready;
        mem_s_n     = mem_s;
        mem_flags_n = mem_flags;
        wr_ptr_n    = wr_ptr;
        rd_ptr_n    = rd_ptr;
        count_n     = count;
        res_count_n = res_count;
        ovf_count_n = ovf_count;

        if (push_c) begin
            mem_s_n[wr_ptr]     = bus.in_s;
            mem_flags_n[wr_ptr] = in_flags_c;
            wr_ptr_n            = ~wr_ptr;
        end
        if (pop_c) begin
            rd_ptr_n = ~rd_ptr;
        end

        unique case ({push_c, pop_c})
            2'b10:   count_n = count + 2'd1;
            2'b01:   count_n = count - 2'd1;
            default: count_n = count;
        endcase

        // clr wins over a same-cycle increment; counters stick at all-ones.
        if (clr) begin
            res_count_n = '0;
            ovf_count_n = '0;
        end else if (pop_c) begin
            if (res_count != '1) begin
                res_count_n = res_count + CNT_W'(1);
            end
            if (bus.out_flags[OVF_B] && (ovf_count != '1)) begin
                ovf_count_n = ovf_count + CNT_W'(1);
            end
        end
    end

    // State and registered outputs; head outputs track the next read entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_s         <= '{default: '0};
            mem_flags     <= '{default: '0};
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            count         <= 2'd0;
            res_count     <= '0;
            ovf_count     <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_s     <= '0;
            bus.out_flags <= '0;
        end else begin
            mem_s         <= mem_s_n;
            mem_flags     <= mem_flags_n;
            wr_ptr        <= wr_ptr_n;
            rd_ptr        <= rd_ptr_n;
            count         <= count_n;
            res_count     <= res_count_n;
            ovf_count     <= ovf_count_n;
            bus.in_ready  <= (count_n != 2'd2);
            bus.out_valid <= (count_n != 2'd0);
            bus.out_s     <= mem_s_n[rd_ptr_n];
            bus.out_flags <= mem_flags_n[rd_ptr_n];
        end
    end
endmodule

// File: tb/tb_addsub_result_stage.sv
// Directed bench for addsub_result_stage: a CNT_W=8 instance for the
// functional vectors and a CNT_W=2 instance for counter saturation/clr.
module tb_addsub_result_stage;
    localparam int unsigned W = 4;

    logic clk;
    logic rst_n;
    logic clr;
    logic s_clr;
    logic [7:0] res_count, ovf_count;
    logic [1:0] s_res, s_ovf;

    int total = 0;
    int bad   = 0;

    addsub_result_stage_if #(.W(W)) u_if ();
    addsub_result_stage_if #(.W(W)) s_if ();

    addsub_result_stage #(.W(W), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(u_if.slave), .clr(clr),
        .res_count(res_count), .ovf_count(ovf_count)
    );

    addsub_result_stage #(.W(W), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(s_if.slave), .clr(s_clr),
        .res_count(s_res), .ovf_count(s_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [3:0] a, input logic [3:0] b, input logic mode,
                            input logic [3:0] s, input logic cout);
        int n;
        u_if.in_a     = a;
        u_if.in_b     = b;
        u_if.in_mode  = mode;
        u_if.in_s     = s;
        u_if.in_cout  = cout;
        u_if.in_valid = 1'b1;
        n = 0;
        while (!u_if.in_ready && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) check("push_timeout", 32'd0, 32'd1);
        step();
        u_if.in_valid = 1'b0;
    endtask

    task automatic pop_one();
        u_if.out_ready = 1'b1;
        step();
        u_if.out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clr = 1'b0;
        s_clr = 1'b0;
        u_if.in_valid = 1'b0; u_if.in_a = '0; u_if.in_b = '0; u_if.in_mode = 1'b0;
        u_if.in_s = '0; u_if.in_cout = 1'b0; u_if.out_ready = 1'b0;
        s_if.in_valid = 1'b0; s_if.in_a = '0; s_if.in_b = '0; s_if.in_mode = 1'b0;
        s_if.in_s = '0; s_if.in_cout = 1'b0; s_if.out_ready = 1'b0;

        // reset state
        #12;
        check("rst_in_ready", 32'(u_if.in_ready), 32'd1);
        check("rst_out_valid", 32'(u_if.out_valid), 32'd0);
        check("rst_out_s", 32'(u_if.out_s), 32'd0);
        check("rst_out_flags", 32'(u_if.out_flags), 32'd0);
        check("rst_res_count", 32'(res_count), 32'd0);
        check("rst_ovf_count", 32'(ovf_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // add, no overflow: 5 + (-2) = 3, carry out
        push_one(4'b0101, 4'b1110, 1'b0, 4'b0011, 1'b1);
        check("add_valid", 32'(u_if.out_valid), 32'd1);
        check("add_s", 32'(u_if.out_s), 32'h3);
        check("add_flags", 32'(u_if.out_flags), 32'b00001);
        pop_one();
        check("add_empty", 32'(u_if.out_valid), 32'd0);
        check("add_res", 32'(res_count), 32'd1);
        check("add_ovf_cnt", 32'(ovf_count), 32'd0);

        // add, signed overflow: 6 + 2 = 8
        push_one(4'b0110, 4'b0010, 1'b0, 4'b1000, 1'b0);
        check("addovf_s", 32'(u_if.out_s), 32'h8);
        check("addovf_flags", 32'(u_if.out_flags), 32'b11000);
        pop_one();
        check("addovf_res", 32'(res_count), 32'd2);
        check("addovf_ovf_cnt", 32'(ovf_count), 32'd1);

        // subtract with borrow: 5 - (-2) = 7, no overflow
        push_one(4'b0101, 4'b1110, 1'b1, 4'b0111, 1'b0);
        check("sub_s", 32'(u_if.out_s), 32'h7);
        check("sub_flags", 32'(u_if.out_flags), 32'b00010);
        pop_one();
        // subtract, no borrow: 6 - 2 = 4
        push_one(4'b0110, 4'b0010, 1'b1, 4'b0100, 1'b1);
        check("sub2_s", 32'(u_if.out_s), 32'h4);
        check("sub2_flags", 32'(u_if.out_flags), 32'b00000);
        pop_one();
        // subtract to zero: 3 - 3
        push_one(4'b0011, 4'b0011, 1'b1, 4'b0000, 1'b1);
        check("zero_flags", 32'(u_if.out_flags), 32'b00100);
        pop_one();
        // subtract overflow: -8 - 1 = 7 (wrapped)
        push_one(4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1);
        check("subovf_flags", 32'(u_if.out_flags), 32'b10000);
        pop_one();
        check("sub_res", 32'(res_count), 32'd6);
        check("sub_ovf_cnt", 32'(ovf_count), 32'd2);

        // backpressure and ordering
        push_one(4'd1, 4'd1, 1'b0, 4'd2, 1'b0);
        check("bp_rdy1", 32'(u_if.in_ready), 32'd1);
        push_one(4'd2, 4'd2, 1'b0, 4'd4, 1'b0);
        check("bp_full_rdy", 32'(u_if.in_ready), 32'd0);
        u_if.in_a = 4'd3; u_if.in_b = 4'd3; u_if.in_mode = 1'b0;
        u_if.in_s = 4'd6; u_if.in_cout = 1'b0; u_if.in_valid = 1'b1;
        step();
        step();
        check("bp_held_rdy", 32'(u_if.in_ready), 32'd0);
        check("bp_head_stable", 32'(u_if.out_s), 32'd2);
        u_if.out_ready = 1'b1;
        step();
        check("bp_rdy_after_pop", 32'(u_if.in_ready), 32'd1);
        check("bp_order2", 32'(u_if.out_s), 32'd4);
        step();
        u_if.in_valid = 1'b0;
        check("bp_order3", 32'(u_if.out_s), 32'd6);
        check("bp_valid3", 32'(u_if.out_valid), 32'd1);
        step();
        u_if.out_ready = 1'b0;
        check("bp_drained", 32'(u_if.out_valid), 32'd0);
        check("bp_res", 32'(res_count), 32'd9);

        // clear counters, FIFO untouched
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_res", 32'(res_count), 32'd0);
        check("clr_ovf", 32'(ovf_count), 32'd0);

        // simultaneous push/pop at count=1
        push_one(4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        u_if.in_valid = 1'b1;
        u_if.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            u_if.in_s = 4'(i + 1);
            check("pp_head", 32'(u_if.out_s), 32'(i));
            check("pp_rdy", 32'(u_if.in_ready), 32'd1);
            step();
        end
        u_if.in_valid = 1'b0;
        u_if.out_ready = 1'b0;
        check("pp_res", 32'(res_count), 32'd10);
        check("pp_ovf", 32'(ovf_count), 32'd2);
        check("pp_last", 32'(u_if.out_s), 32'd10);
        check("pp_last_valid", 32'(u_if.out_valid), 32'd1);
        pop_one();
        check("pp_empty", 32'(u_if.out_valid), 32'd0);

        // saturation and clr on the 2-bit counter instance
        s_if.in_a = 4'b0110; s_if.in_b = 4'b0010; s_if.in_mode = 1'b0;
        s_if.in_s = 4'b1000; s_if.in_cout = 1'b0;
        s_if.in_valid = 1'b1;
        s_if.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("sat_res", 32'(s_res), 32'd3);
        check("sat_ovf", 32'(s_ovf), 32'd3);
        s_clr = 1'b1;
        check("sat_pop_pending", 32'(s_if.out_valid), 32'd1);
        step();
        s_clr = 1'b0;
        check("sat_clr_res", 32'(s_res), 32'd0);
        check("sat_clr_ovf", 32'(s_ovf), 32'd0);
        s_if.in_valid = 1'b0;
        step();
        s_if.out_ready = 1'b0;

        // asynchronous reset with the FIFO full
        push_one(4'd1, 4'd1, 1'b0, 4'd2, 1'b0);
        push_one(4'd2, 4'd2, 1'b0, 4'd4, 1'b0);
        check("full_rdy", 32'(u_if.in_ready), 32'd0);
        check("full_valid", 32'(u_if.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(u_if.out_valid), 32'd0);
        check("arst_rdy", 32'(u_if.in_ready), 32'd1);
        check("arst_out_s", 32'(u_if.out_s), 32'd0);
        check("arst_res", 32'(res_count), 32'd0);
        #3;
        rst_n = 1'b1;
        step();
        step();
        check("post_rst_valid", 32'(u_if.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
